// File: rtl/anim_pkg.sv
// anim_pkg: animation state encoding, default frame counts and sprite base lookup
// Rev 1.0
`default_nettype none

package anim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    JUMP   = 2'd2,
    ATTACK = 2'd3
  } anim_state_t;

  localparam int FRAME_HOLD_DEF    = 6;
  localparam int RUN_FRAMES_DEF    = 4;
  localparam int JUMP_FRAMES_DEF   = 2;
  localparam int ATTACK_FRAMES_DEF = 3;
  localparam int ID_W_DEF          = 5;

  // Sprite ROM layout: one idle frame, then run, jump and attack strips back to back
  function automatic int base_of(input anim_state_t s,
                                 input int run_f  = RUN_FRAMES_DEF,
                                 input int jump_f = JUMP_FRAMES_DEF);
    case (s)
      IDLE:    base_of = 0;
      RUN:     base_of = 1;
      JUMP:    base_of = 1 + run_f;
      default: base_of = 1 + run_f + jump_f;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vsync_tick.sv
// vsync_tick: falling-edge detector on active-low vsync, one-cycle tick output
// Rev 1.0
`default_nettype none

module vsync_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic tick
);

  logic vs_q;

  // Resets high so a vsync already low at release does not count as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b1;
    else        vs_q <= vs;
  end

  assign tick = vs_q & ~vs;

endmodule

`default_nettype wire

// File: rtl/anim_sequencer.sv
// anim_sequencer: per-character animation FSM, updates only on vsync ticks.
// Optional macro ANIM_PAUSE_EN adds a pause input that freezes tick processing. Rev 1.0
`default_nettype none

module anim_sequencer
  import anim_pkg::*;
#(
  parameter int FRAME_HOLD    = FRAME_HOLD_DEF,
  parameter int RUN_FRAMES    = RUN_FRAMES_DEF,
  parameter int JUMP_FRAMES   = JUMP_FRAMES_DEF,
  parameter int ATTACK_FRAMES = ATTACK_FRAMES_DEF,
  parameter int ID_W          = ID_W_DEF
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  input  logic            vs,
  input  logic            move_left,
  input  logic            move_right,
  input  logic            jump_req,
  input  logic            attack_req,
  input  logic            on_ground,
`ifdef ANIM_PAUSE_EN
  input  logic            pause,
`endif
  output anim_state_t     anim_state,
  output logic [2:0]      frame_idx,
  output logic [ID_W-1:0] sprite_id,
  output logic            facing_left,
  output logic            attack_active
);

  localparam logic [5:0] HOLD_LAST = 6'(FRAME_HOLD - 1);
  localparam logic [2:0] RUN_LAST  = 3'(RUN_FRAMES - 1);
  localparam logic [2:0] JUMP_LAST = 3'(JUMP_FRAMES - 1);
  localparam logic [2:0] ATK_LAST  = 3'(ATTACK_FRAMES - 1);

  logic        tick;
  logic        step;
  logic [5:0]  hold;
  logic        attack_pend;

  logic        mv_one;
  logic        hold_done;
  logic        leave;
  logic        restart;
  anim_state_t pick_state;
  logic        pick_facing;
  anim_state_t nxt_state;
  logic        nxt_facing;
  logic [2:0]  adv_frame;
  logic [2:0]  nxt_frame;
  logic [5:0]  nxt_hold;

  vsync_tick u_vsync_tick (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .vs    (vs),
    .tick  (tick)
  );

`ifdef ANIM_PAUSE_EN
  assign step = tick & ~pause;
`else
  assign step = tick;
`endif

  always_comb begin
    mv_one    = move_left ^ move_right;
    hold_done = (hold == HOLD_LAST);

    // Shared exit priority list used by IDLE, RUN and the exits of JUMP/ATTACK
    pick_facing = facing_left;
    if (attack_pend) begin
      pick_state = ATTACK;
    end else if (jump_req && on_ground) begin
      pick_state = JUMP;
    end else if (mv_one) begin
      pick_state  = RUN;
      pick_facing = move_left;
    end else begin
      pick_state = IDLE;
    end

    adv_frame = frame_idx;
    if (hold_done) begin
      case (anim_state)
        RUN:     adv_frame = (frame_idx == RUN_LAST) ? 3'd0 : frame_idx + 3'd1;
        JUMP:    adv_frame = (frame_idx == JUMP_LAST) ? JUMP_LAST : frame_idx + 3'd1;
        ATTACK:  adv_frame = frame_idx + 3'd1;
        default: adv_frame = 3'd0;
      endcase
    end

    case (anim_state)
      IDLE, RUN: leave = 1'b1;
      JUMP:      leave = on_ground && (frame_idx == JUMP_LAST);
      default:   leave = hold_done && (frame_idx == ATK_LAST);
    endcase

    // IDLE and RUN staying put keep their frame count; JUMP/ATTACK re-entry restarts
    restart = leave && ((pick_state != anim_state) ||
                        (anim_state == JUMP) || (anim_state == ATTACK));

    nxt_state  = anim_state;
    nxt_facing = facing_left;
    nxt_frame  = adv_frame;
    nxt_hold   = hold_done ? 6'd0 : hold + 6'd1;
    if (leave) begin
      nxt_state  = pick_state;
      nxt_facing = pick_facing;
    end else if ((anim_state == JUMP) && mv_one) begin
      nxt_facing = move_left;
    end
    if (restart) begin
      nxt_frame = 3'd0;
      nxt_hold  = 6'd0;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      anim_state    <= IDLE;
      frame_idx     <= 3'd0;
      hold          <= 6'd0;
      facing_left   <= 1'b0;
      sprite_id     <= '0;
      attack_active <= 1'b0;
      attack_pend   <= 1'b0;
    end else begin
      if (attack_req)
        attack_pend <= 1'b1;
      else if (step && restart && (nxt_state == ATTACK))
        attack_pend <= 1'b0;

      if (step) begin
        anim_state    <= nxt_state;
        frame_idx     <= nxt_frame;
        hold          <= nxt_hold;
        facing_left   <= nxt_facing;
        sprite_id     <= ID_W'(base_of(nxt_state, RUN_FRAMES, JUMP_FRAMES) + int'(nxt_frame));
        attack_active <= (nxt_state == ATTACK);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: directed stimulus with a per-cycle behavioural model and literal pins.
// Rev 1.0
`default_nettype none

module tb_anim_sequencer;

  localparam int FH = 6;
  localparam int RF = 4;
  localparam int JF = 2;
  localparam int AF = 3;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic vs = 1'b1;
  logic move_left = 1'b0;
  logic move_right = 1'b0;
  logic jump_req = 1'b0;
  logic attack_req = 1'b0;
  logic on_ground = 1'b1;
`ifdef ANIM_PAUSE_EN
  logic pause = 1'b0;
`endif

  logic [1:0]    anim_state;
  logic [2:0]    frame_idx;
  logic [IW-1:0] sprite_id;
  logic          facing_left;
  logic          attack_active;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  anim_sequencer #(
    .FRAME_HOLD(FH), .RUN_FRAMES(RF), .JUMP_FRAMES(JF), .ATTACK_FRAMES(AF), .ID_W(IW)
  ) dut (
    .vga_clk       (clk),
    .reset_n       (reset_n),
    .vs            (vs),
    .move_left     (move_left),
    .move_right    (move_right),
    .jump_req      (jump_req),
    .attack_req    (attack_req),
    .on_ground     (on_ground),
`ifdef ANIM_PAUSE_EN
    .pause         (pause),
`endif
    .anim_state    (anim_state),
    .frame_idx     (frame_idx),
    .sprite_id     (sprite_id),
    .facing_left   (facing_left),
    .attack_active (attack_active)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int st;
    int fr;
    int hd;
    bit fc;
    bit pd;
  } mstate_t;

  localparam mstate_t M_RESET = '{st: 0, fr: 0, hd: 0, fc: 1'b0, pd: 1'b0};

  mstate_t m;
  bit      m_vsq;

  function automatic int frames_of(input int s);
    case (s)
      0:       frames_of = 1;
      1:       frames_of = RF;
      2:       frames_of = JF;
      default: frames_of = AF;
    endcase
  endfunction

  function automatic int base_model(input int s);
    case (s)
      0:       base_model = 0;
      1:       base_model = 1;
      2:       base_model = 1 + RF;
      default: base_model = 1 + RF + JF;
    endcase
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input bit tk, input bit ml,
                                         input bit mr, input bit jr, input bit og, input bit ar);
    mstate_t n;
    int      ns;
    bit      nf;
    bit      lv;
    bit      expire;
    n = c;
    if (tk) begin
      expire = (c.hd == FH - 1);
      case (c.st)
        0, 1:    lv = 1'b1;
        2:       lv = og && (c.fr == JF - 1);
        default: lv = expire && (c.fr == AF - 1);
      endcase
      nf = c.fc;
      if (c.pd)               ns = 3;
      else if (jr && og)      ns = 2;
      else if (ml != mr) begin ns = 1; nf = ml; end
      else                    ns = 0;
      if (lv && (ns != c.st || ns >= 2)) begin
        n.st = ns; n.fc = nf; n.fr = 0; n.hd = 0;
        if (ns == 3) n.pd = 1'b0;
      end else begin
        if (lv) n.fc = nf;
        else if (c.st == 2 && ml != mr) n.fc = ml;
        if (expire) begin
          n.hd = 0;
          if (c.st == 2) n.fr = (c.fr + 1 > JF - 1) ? JF - 1 : c.fr + 1;
          else           n.fr = (c.fr + 1) % frames_of(c.st);
        end else begin
          n.hd = c.hd + 1;
        end
      end
    end
    if (ar) n.pd = 1'b1;
    return n;
  endfunction

  function automatic bit model_tick(input bit vsq, input bit v);
    bit t;
    t = vsq && !v;
`ifdef ANIM_PAUSE_EN
    if (pause) t = 1'b0;
`endif
    return t;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m     <= M_RESET;
      m_vsq <= 1'b1;
    end else begin
      m     <= model_next(m, model_tick(m_vsq, vs), move_left, move_right,
                          jump_req, on_ground, attack_req);
      m_vsq <= vs;
    end
  end

  // ---------------- checking ----------------
  task automatic compare_loop();
    logic [11:0] exp_v;
    logic [11:0] act_v;
    forever begin
      @(negedge clk);
      exp_v = {2'(m.st), 3'(m.fr), IW'(base_model(m.st) + m.fr), m.fc, (m.st == 3)};
      act_v = {anim_state, frame_idx, sprite_id, facing_left, attack_active};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model_cycle t=%0t actual st=%0d fr=%0d id=%0d fl=%0d aa=%0d required st=%0d fr=%0d id=%0d fl=%0d aa=%0d",
                 $time, act_v[11:10], act_v[9:7], act_v[6:2], act_v[1], act_v[0],
                 exp_v[11:10], exp_v[9:7], exp_v[6:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_out(input string name, input int st, input int id, input int fl);
    chk({name, "_state"}, int'(anim_state), st);
    chk({name, "_sprite"}, int'(sprite_id), id);
    chk({name, "_facing"}, int'(facing_left), fl);
    chk({name, "_attack"}, int'(attack_active), (st == 3) ? 1 : 0);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vs = 1'b0;
      @(negedge clk) vs = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_attack();
    @(negedge clk) attack_req = 1'b1;
    @(negedge clk) attack_req = 1'b0;
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Run right through a full cycle
    move_right = 1'b1;
    do_ticks(1);  chk_out("run_first", 1, 1, 0);
    do_ticks(6);  chk_out("run_plus6", 1, 2, 0);
    do_ticks(12); chk_out("run_plus18", 1, 4, 0);
    do_ticks(6);  chk_out("run_wrap", 1, 1, 0);

    // Attack while running; facing frozen, then exit to RUN left
    pulse_attack();
    do_ticks(1);  chk_out("atk_enter", 3, 7, 0);
    move_left = 1'b1;
    move_right = 1'b0;
    do_ticks(6);  chk_out("atk_f1", 3, 8, 0);
    do_ticks(6);  chk_out("atk_f2", 3, 9, 0);
    do_ticks(6);  chk_out("atk_exit", 1, 1, 1);

    // Both directions: IDLE, facing kept
    move_right = 1'b1;
    do_ticks(1);  chk_out("both_idle", 0, 0, 1);

    // Jump, hold in air, land
    move_left = 1'b0;
    move_right = 1'b0;
    jump_req = 1'b1;
    do_ticks(1);  chk_out("jump_enter", 2, 5, 1);
    jump_req = 1'b0;
    do_ticks(6);  chk_out("jump_f1", 2, 6, 1);
    on_ground = 1'b0;
    do_ticks(20); chk_out("jump_air", 2, 6, 1);
    on_ground = 1'b1;
    do_ticks(1);  chk_out("jump_land", 0, 0, 1);

    // Back-to-back attacks through the one-deep queue
    pulse_attack();
    do_ticks(1);  chk_out("atk2_enter", 3, 7, 1);
    pulse_attack();
    do_ticks(17); chk_out("atk2_last", 3, 9, 1);
    do_ticks(1);  chk_out("atk3_enter", 3, 7, 1);
    do_ticks(18); chk_out("atk3_exit", 0, 0, 1);

    // Asynchronous reset mid-run
    move_left = 1'b1;
    do_ticks(8);  chk_out("pre_reset", 1, 2, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0);
    chk("async_reset_frame", int'(frame_idx), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("post_reset_idle", 0, 0, 0);
    do_ticks(1);  chk_out("post_reset_run", 1, 1, 1);
    do_ticks(6);  chk_out("post_reset_adv", 1, 2, 1);

`ifdef ANIM_PAUSE_EN
    do_ticks(3);
    pause = 1'b1;
    do_ticks(10); chk_out("paused", 1, 2, 1);
    pause = 1'b0;
    do_ticks(2);  chk_out("resume_hold", 1, 2, 1);
    do_ticks(1);  chk_out("resume_adv", 1, 3, 1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Per-character animation controller for the sprite renderers.
- Picks the animation (idle/run/jump/attack) and the frame within it from the player's control inputs.
- Emits a registered sprite_id that selects which sprite ROM/palette pair the render mux reads.
- All visible changes happen only at the vertical-sync boundary, so a sprite never changes mid-frame.

Parameters:
- FRAME_HOLD, 6, vsync ticks each animation frame is shown (legal range 1..63).
- RUN_FRAMES, 4, frames in the run cycle.
- JUMP_FRAMES, 2, frames in the jump rise; the last one is held while airborne.
- ATTACK_FRAMES, 3, frames in the one-shot attack.
- ID_W, 5, width of sprite_id.

Ports:
- vga_clk  in  1  pixel clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- vs  in  1  VGA vsync (active-low), same clock domain.
- move_left  in  1  level input.
- move_right  in  1  level input.
- jump_req  in  1  level input.
- attack_req  in  1  pulse or level; latched internally.
- on_ground  in  1  from the physics block.
- anim_state  out  2  current anim_state_t.
- frame_idx  out  3  frame index within the current animation.
- sprite_id  out  ID_W  base[anim_state] + frame_idx.
- facing_left  out  1  1 = mirror the sprite horizontally.
- attack_active  out  1  high while in ATTACK.

Behaviour:
- Reset (reset_n=0, asynchronous) drives these values:
  - anim_state=IDLE, frame_idx=0, sprite_id=0, facing_left=0, attack_active=0.
  - hold counter=0, attack_pend=0, vs_q=1.
- tick:
  - vs_q registers vs each cycle.
  - tick = vs_q & ~vs, i.e. the falling edge of vsync, one cycle wide.
  - All state, frame, facing and sprite_id updates occur only in the cycle after tick; no other cycle changes them.
- attack_pend:
  - Set in any cycle attack_req=1.
  - Cleared on the tick that enters ATTACK.
  - This is a one-deep buffer: an attack_req during ATTACK queues exactly one follow-up attack.
- Sprite bases (sprite_id offsets per animation):
  - IDLE=0 (1 frame).
  - RUN=1.
  - JUMP=1+RUN_FRAMES.
  - ATTACK=1+RUN_FRAMES+JUMP_FRAMES.
- Hold and frame advance, evaluated on each tick:
  - If hold==FRAME_HOLD-1, set hold=0 and advance the frame; otherwise hold+1.
  - Any state change forces frame_idx=0 and hold=0.
- Movement decision ("mv"):
  - Exactly one of move_left/move_right high: RUN, and facing_left=move_left.
  - Both or neither high: IDLE, facing unchanged.
- Decision at a tick from IDLE or RUN, in priority order:
  1. attack_pend: go to ATTACK.
  2. jump_req & on_ground: go to JUMP.
  3. Otherwise apply mv.
  - RUN→RUN keeps frame counting; RUN frames wrap RUN_FRAMES-1 → 0.
- JUMP:
  - Frames advance and saturate at JUMP_FRAMES-1.
  - Facing follows mv.
  - At a tick with on_ground=1 and frame_idx==JUMP_FRAMES-1, exit via the IDLE/RUN priority list (attack allowed, jump allowed).
- ATTACK:
  - Not interruptible; facing is frozen; move and jump inputs are ignored.
  - On the tick where the hold of the last frame expires, leave via the IDLE/RUN priority list.
  - A queued attack_pend re-enters ATTACK at frame 0.
- Register outputs: sprite_id and attack_active are registered together with state, so there is no combinational path from the inputs.
- Outputs with widths smaller than frame_idx are zero-extended; sprite_id additions are ID_W wide with no overflow for the defaults.

Optional Feature:
- Macro: ANIM_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - While pause=1, ticks are ignored: hold, frame, state and facing are frozen.
  - attack_pend still latches.
  - Resuming continues from the same hold count.
- When undefined: no pause port, and every tick is processed.

Decomposition:
- Package anim_pkg holds:
  - anim_state_t enum (IDLE=0, RUN=1, JUMP=2, ATTACK=3).
  - Default frame-count constants.
  - A function base_of(state) returning the sprite_id base.
- One sub-module, vsync_tick: vs edge detector, registered vs_q, one-cycle tick output.

Test Plan:
- Reset mid-run with reset_n=0 asynchronously, no clock edge → all outputs immediately 0; after release, idle until the first tick.
- move_right held, FRAME_HOLD=6:
  - First tick → RUN, sprite_id=1.
  - +6 ticks → 2; +18 → 4; +24 → wraps to 1.
  - facing_left=0 throughout.
- While running right, a 1-cycle attack_req between ticks:
  - Next tick → ATTACK, sprite_id=7, attack_active=1.
  - +6 → 8; +12 → 9.
  - move_left raised during the attack leaves facing_left=0.
  - +18 → RUN with facing_left=1, sprite_id=1.
- jump_req with on_ground=1:
  - → JUMP, sprite_id=5; +6 ticks → 6.
  - Holds 6 while on_ground=0 for 20 ticks.
  - on_ground=1 with no move → IDLE, sprite_id=0.
- move_left and move_right both high from RUN (facing_left=1) → IDLE at the next tick, facing_left stays 1; a second attack_req during ATTACK → a back-to-back second attack restarting at sprite_id=7.
- With ANIM_PAUSE_EN: pause=1 across 10 ticks mid-run → sprite_id and hold unchanged; after pause=0, the frame advances after the remaining ticks only.
